// File: rtl/pixel_uart_tx_pkg.sv
// Shared types and constants for the pixel UART transmitter.
//   - FSM state encoding for the serializer
//   - 8N1 framing constants and the default baud divider
package pixel_uart_tx_pkg;

  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_FIFO_DEPTH   = 16;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef logic [DATA_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage : pixel_uart_tx_pkg

// File: rtl/pixel_uart_tx_if.sv
// Pixel strobe bus from the 3x3 kernel stage.
//   data : filtered pixel, qualified by done
//   done : one-cycle strobe, one pixel per high cycle
// master drives the bus (filter side), slave receives it (UART side).
interface pixel_uart_tx_if;
  import pixel_uart_tx_pkg::*;

  pixel_t data;
  logic   done;

  modport master (output data, output done);
  modport slave  (input  data, input  done);

endinterface : pixel_uart_tx_if

// File: rtl/pixel_uart_tx_fifo.sv
// pixel_fifo: synchronous pixel FIFO decoupling filter bursts from the UART.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   wr_en_i         : push request (dropped when full unless a pop coincides)
//   wr_data_i       : pixel to push
//   rd_en_i         : pop request (ignored when empty)
//   rd_data_c_o     : head entry, combinational read
//   full_o, empty_o : registered occupancy flags
module pixel_fifo
  import pixel_uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en_i,
  input  pixel_t wr_data_i,
  input  logic   rd_en_i,
  output pixel_t rd_data_c_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  pixel_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               wr_fire;
  logic               rd_fire;

  // A pop frees the slot the same cycle, so a push into a full FIFO succeeds then.
  assign rd_fire = rd_en_i && !empty_q;
  assign wr_fire = wr_en_i && (!full_q || rd_fire);

  // Pointer/count update; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_fire) - CNT_W'(rd_fire);
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_c_o = mem_q[rd_ptr_q];
  assign full_o      = full_q;
  assign empty_o     = empty_q;

endmodule : pixel_fifo

// File: rtl/pixel_uart_tx.sv
// pixel_uart_tx: queues filtered pixels and serializes them as 8N1 UART.
// Ports:
//   clk, rst_n  : clock, async active-low reset (abandons any frame in flight)
//   pix         : pixel strobe bus (slave side)
//   tx_o        : registered UART line, idles high
//   busy_o      : FIFO non-empty or frame in flight
//   overflow_o  : sticky, set when a pixel is dropped on a full FIFO
module pixel_uart_tx
  import pixel_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pixel_uart_tx_if.slave         pix,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  pixel_t            shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;

  logic              pop;
  logic              baud_last;
  logic              accept;
  logic              drop;
  pixel_t            fifo_head;
  logic              fifo_full;
  logic              fifo_empty;

  pixel_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (pix.done),
    .wr_data_i   (pix.data),
    .rd_en_i     (pop),
    .rd_data_c_o (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Push outcome mirrors the FIFO's own accept rule; pop only fires when non-empty.
  assign accept = pix.done && (!fifo_full || pop);
  assign drop   = pix.done && fifo_full && !pop;

  // Serializer next-state, baud/bit counters and shift register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more pixels wait.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and status flags, decoded from the next state so they register cleanly.
  always_comb begin
    tx_d = STOP_BIT;
    case (state_d)
      ST_IDLE:  tx_d = STOP_BIT;
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = shift_d[0];
      ST_STOP:  tx_d = STOP_BIT;
      default:  tx_d = STOP_BIT;
    endcase
    busy_d = (state_d != ST_IDLE) || accept || !fifo_empty;
    ovf_d  = ovf_q || drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

endmodule : pixel_uart_tx

// File: tb/tb_pixel_uart_tx.sv
// Testbench for pixel_uart_tx: vector table of single frames, hand-written
// multi-cycle sequences, and a UART receiver feeding a byte scoreboard.
module tb_pixel_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tx_o;
  logic busy_o;
  logic overflow_o;

  pixel_uart_tx_if pix_if ();

  pixel_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix        (pix_if.slave),
    .tx_o       (tx_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  logic [7:0]  exp_q[$];
  int unsigned starts_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one pixel for one clock; caller sits just after a rising edge.
  task automatic strobe(input logic [7:0] d, input bit acc);
    pix_if.data = d;
    pix_if.done = 1'b1;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
    pix_if.done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // UART receiver: samples mid-bit on falling edges, checks each frame against the scoreboard.
  bit          mon_active = 1'b0;
  int unsigned mon_cnt    = 0;
  logic [9:0]  mon_frame  = '0;
  logic [7:0]  mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        mon_cnt    = 0;
      end else begin
        if (!mon_active && tx_o == 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          starts_q.push_back(cyc);
        end
        if (mon_active) begin
          if (mon_cnt % CPB == CPB / 2) mon_frame[mon_cnt / CPB] = tx_o;
          mon_cnt++;
          if (mon_cnt == FRAME) begin
            mon_active = 1'b0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", mon_frame[8:1]);
            end else begin
              mon_exp = exp_q.pop_front();
              check("rx_byte", 32'(mon_frame[8:1]), 32'(mon_exp));
              check("rx_start_bit", 32'(mon_frame[0]), 32'(1'b0));
              check("rx_stop_bit", 32'(mon_frame[9]), 32'(1'b1));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // transmitted bits, bit 0 first on the line
  } vec_t;

  vec_t        vecs[5];
  logic [9:0]  got_frame;
  bit          stable_f;
  bit          low_seen;

  initial begin
    pix_if.data = '0;
    pix_if.done = 1'b0;

    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h3C, frame: 10'h278};
    vecs[4] = '{data: 8'h81, frame: 10'h302};

    // Asynchronous reset values, before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx_o), 32'(1'b1));
    check("rst_busy", 32'(busy_o), 32'(1'b0));
    check("rst_ovf", 32'(overflow_o), 32'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-byte frames: exact per-cycle waveform, start latency, busy/overflow
    for (int i = 0; i < 5; i++) begin
      strobe(vecs[i].data, 1'b1);
      check("tx_idle_after_push", 32'(tx_o), 32'(1'b1));
      check("busy_rise", 32'(busy_o), 32'(1'b1));
      got_frame = '0;
      stable_f  = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < int'(FRAME); k++) begin
        if (k % CPB == 0) got_frame[k / CPB] = tx_o;
        else if (tx_o !== got_frame[k / CPB]) stable_f = 1'b0;
        @(posedge clk);
        #1;
      end
      check("frame_bits", 32'(got_frame), 32'(vecs[i].frame));
      check("frame_bit_hold", 32'(stable_f), 32'(1'b1));
      check("busy_fall", 32'(busy_o), 32'(1'b0));
      check("ovf_single", 32'(overflow_o), 32'(1'b0));
      check("tx_idle_end", 32'(tx_o), 32'(1'b1));
      check("sb_drained", 32'(exp_q.size()), 32'(0));
    end

    // Back-to-back frames with no idle gap
    do_reset();
    starts_q.delete();
    strobe(8'h00, 1'b1);
    strobe(8'hFF, 1'b1);
    repeat (90) @(posedge clk);
    #1;
    check("b2b_frame_count", 32'(starts_q.size()), 32'(2));
    if (starts_q.size() == 2)
      check("b2b_gap", 32'(starts_q[1] - starts_q[0]), 32'(FRAME));
    check("b2b_drained", 32'(exp_q.size()), 32'(0));
    check("b2b_busy", 32'(busy_o), 32'(1'b0));

    // Full FIFO with a push landing exactly on the last STOP cycle (pop cycle)
    do_reset();
    strobe(8'h11, 1'b1);
    strobe(8'h22, 1'b1);
    strobe(8'h33, 1'b1);
    strobe(8'h44, 1'b1);
    strobe(8'h55, 1'b1);
    check("fill_no_ovf", 32'(overflow_o), 32'(1'b0));
    repeat (36) @(posedge clk);
    #1;
    strobe(8'h3C, 1'b1);
    check("full_pop_no_ovf", 32'(overflow_o), 32'(1'b0));
    repeat (215) @(posedge clk);
    #1;
    check("full_pop_drained", 32'(exp_q.size()), 32'(0));
    check("full_pop_ovf_end", 32'(overflow_o), 32'(1'b0));
    check("full_pop_busy", 32'(busy_o), 32'(1'b0));

    // Overflow: 7 consecutive pixels, 01..05 survive
    do_reset();
    for (int v = 1; v <= 7; v++) begin
      strobe(8'(v), v <= 5);
      if (v == 5) check("ovf_before_drop", 32'(overflow_o), 32'(1'b0));
      if (v == 6) check("ovf_at_drop", 32'(overflow_o), 32'(1'b1));
    end
    repeat (205) @(posedge clk);
    #1;
    check("ovf_sticky", 32'(overflow_o), 32'(1'b1));
    check("ovf_drained", 32'(exp_q.size()), 32'(0));
    check("ovf_busy", 32'(busy_o), 32'(1'b0));

    // Reset during DATA bit 3, then a clean frame
    do_reset();
    strobe(8'h5A, 1'b1);
    repeat (18) @(posedge clk);
    #2;
    check("busy_before_rst", 32'(busy_o), 32'(1'b1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tx", 32'(tx_o), 32'(1'b1));
    check("midrst_busy", 32'(busy_o), 32'(1'b0));
    check("midrst_ovf", 32'(overflow_o), 32'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    low_seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) low_seen = 1'b1;
    end
    check("no_residual_frame", 32'(low_seen), 32'(1'b0));
    strobe(8'hC3, 1'b1);
    repeat (45) @(posedge clk);
    #1;
    check("post_rst_drained", 32'(exp_q.size()), 32'(0));
    check("post_rst_busy", 32'(busy_o), 32'(1'b0));
    check("post_rst_tx", 32'(tx_o), 32'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pixel_uart_tx
